rpn_program_sequencer: RTL and testbench

- Hardware initiator for STACK_BASED_ALU. It replaces bench-driven opcode sequencing with a loadable RPN program.
- It fetches instructions from an internal program memory and drives the ALU's opcode/data inputs one instruction at a time.
- It captures POP results and overflow, and guards against stack underflow and overflow using the ALU's sp.
- It sits beside STACK_BASED_ALU and shares clk/rst with it.

---
 rtl/rpn_program_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_rpn_program_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_program_sequencer.sv
// rpn_program_sequencer: runs a loadable RPN program on the stack ALU.
// Ports: clk/rst; prog_we/prog_addr/prog_wdata load the program memory;
// start/busy/done/error/pc report run status; alu_opcode/alu_data drive
// the ALU; alu_result/alu_overflow/alu_sp come back from it; result,
// result_valid and ovf_flag carry the captured POP value and overflow.
module rpn_program_sequencer #(
    parameter int N           = 4,
    parameter int PROG_DEPTH  = 32,
    parameter int AW          = 5,
    parameter int STACK_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [N+2:0]  prog_wdata,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] pc,
    output logic [2:0]    alu_opcode,
    output logic [N-1:0]  alu_data,
    input  logic [N-1:0]  alu_result,
    input  logic          alu_overflow,
    input  logic [4:0]    alu_sp,
    output logic [N-1:0]  result,
    output logic          result_valid,
    output logic          ovf_flag
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_SETTLE, S_DONE
    } state_t;

    localparam logic [2:0] OP_HALT = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [4:0]    SP_FULL = 5'(STACK_DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(PROG_DEPTH - 1);

    logic [N+2:0] mem [PROG_DEPTH];
    logic [N+2:0] ir;
    logic [N+2:0] fetch_w;
    logic [2:0]   ir_op;

    state_t        state, state_d;
    logic [AW-1:0] pc_d;
    logic [N+2:0]  ir_d;
    logic          busy_d, done_d, error_d, rv_d, ovf_d;
    logic [N-1:0]  result_d, data_d;
    logic [2:0]    op_d;

    assign fetch_w = mem[pc];
    assign ir_op   = ir[N+2:N];

    // True when op may be sent to the ALU with the given stack depth.
    // HALT and reserved codes never reach the ALU.
    function automatic logic can_issue(input logic [2:0] op,
                                       input logic [4:0] sp);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_POP:         ok = (sp >= 5'd1);
            OP_ADD, OP_MUL: ok = (sp >= 5'd2);
            OP_PUSH:        ok = (sp != SP_FULL);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_ff @(posedge clk) begin
        if (state == S_IDLE && prog_we) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    always_comb begin
        state_d  = state;
        pc_d     = pc;
        ir_d     = ir;
        busy_d   = busy;
        done_d   = 1'b0;
        error_d  = error;
        result_d = result;
        rv_d     = 1'b0;
        ovf_d    = ovf_flag;
        op_d     = OP_HALT;
        data_d   = '0;
        unique case (state)
            S_IDLE: begin
                busy_d = start;
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    error_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            S_FETCH: begin
                ir_d    = fetch_w;
                state_d = S_ISSUE;
                // alu_sp is stable until an op is issued, so the
                // issue decision can be registered one cycle early.
                if (can_issue(fetch_w[N+2:N], alu_sp)) begin
                    op_d   = fetch_w[N+2:N];
                    data_d = fetch_w[N-1:0];
                end
            end
            S_ISSUE: begin
                if (ir_op == OP_HALT) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (!can_issue(ir_op, alu_sp)) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (ir_op == OP_POP) begin
                    result_d = alu_result;
                    rv_d     = 1'b1;
                end
                if ((ir_op == OP_ADD || ir_op == OP_MUL) && alu_overflow) begin
                    ovf_d = 1'b1;
                end
                if (pc == LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    pc_d    = pc + AW'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= '0;
            ir           <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            ovf_flag     <= 1'b0;
            alu_opcode   <= OP_HALT;
            alu_data     <= '0;
        end else begin
            state        <= state_d;
            pc           <= pc_d;
            ir           <= ir_d;
            busy         <= busy_d;
            done         <= done_d;
            error        <= error_d;
            result       <= result_d;
            result_valid <= rv_d;
            ovf_flag     <= ovf_d;
            alu_opcode   <= op_d;
            alu_data     <= data_d;
        end
    end

endmodule

// File: tb/tb_rpn_program_sequencer.sv
// tb_rpn_program_sequencer: bench for rpn_program_sequencer with a
// behavioural stack ALU beside it and a queue-based program model.
module tb_rpn_program_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       prog_we = 1'b0;
    logic [4:0] prog_addr = '0;
    logic [6:0] prog_wdata = '0;
    logic       start = 1'b0;
    logic       busy, done, error;
    logic [4:0] pc;
    logic [2:0] alu_opcode;
    logic [3:0] alu_data;
    logic [3:0] alu_result;
    logic       alu_overflow;
    logic [4:0] alu_sp;
    logic [3:0] result;
    logic       result_valid, ovf_flag;

    always #5 clk = ~clk;

    rpn_program_sequencer dut (
        .clk(clk), .rst(rst), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .start(start), .busy(busy), .done(done), .error(error),
        .pc(pc), .alu_opcode(alu_opcode), .alu_data(alu_data),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .alu_sp(alu_sp), .result(result),
        .result_valid(result_valid), .ovf_flag(ovf_flag)
    );

    function automatic int sx(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    function automatic int wrap4(input int v);
        return ((v + 8) & 15) - 8;
    endfunction

    // Behavioural stack ALU: ops take effect at the clock edge.
    logic [3:0] st [16];
    int a_v, b_v, s_v;
    always @(posedge clk) begin
        if (rst) begin
            alu_sp       <= '0;
            alu_result   <= '0;
            alu_overflow <= 1'b0;
        end else begin
            case (alu_opcode)
                3'b110: begin
                    if (alu_sp < 5'd16) st[alu_sp[3:0]] <= alu_data;
                    alu_sp <= alu_sp + 5'd1;
                end
                3'b111: if (alu_sp > 5'd0) begin
                    alu_result <= st[4'(alu_sp - 5'd1)];
                    alu_sp     <= alu_sp - 5'd1;
                end
                3'b100, 3'b101: if (alu_sp > 5'd1) begin
                    a_v = sx(st[4'(alu_sp - 5'd1)]);
                    b_v = sx(st[4'(alu_sp - 5'd2)]);
                    s_v = (alu_opcode == 3'b100) ? a_v + b_v : a_v * b_v;
                    st[4'(alu_sp - 5'd2)] <= 4'(s_v);
                    alu_overflow <= (s_v > 7) || (s_v < -8);
                    alu_sp <= alu_sp - 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Output monitor; cleared when a run is launched.
    int         rvc, donec, b2b, dbad;
    logic [6:0] iss_q[$];
    logic [2:0] prev_op = '0;
    always @(negedge clk) begin
        if (rst || (start && !busy)) begin
            rvc = 0; donec = 0; b2b = 0; dbad = 0;
            iss_q.delete();
        end else begin
            if (result_valid) rvc++;
            if (done) donec++;
            if (alu_opcode != 3'b000) begin
                iss_q.push_back({alu_opcode, alu_data});
                if (prev_op != 3'b000) b2b++;
            end else if (alu_data != 4'd0) begin
                dbad++;
            end
        end
        prev_op = alu_opcode;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    logic [6:0] prog [32];

    // Reference: interpret the program with a queue stack.
    int         m_res = 0;
    int         m_rv, m_ovf, m_err, m_pc, m_cyc;
    logic [6:0] m_iss[$];

    task automatic model();
        int stk[$];
        int a, b, s;
        logic [2:0] op;
        m_rv = 0; m_ovf = 0; m_err = 0; m_pc = 0; m_cyc = 0;
        m_iss.delete();
        for (int i = 0; i < 32; i++) begin
            op   = prog[i][6:4];
            m_pc = i;
            if (op == 3'b000) begin
                m_cyc += 2;
                break;
            end
            if ((op inside {3'd1, 3'd2, 3'd3}) ||
                (op == 3'd7 && stk.size() < 1) ||
                (op inside {3'd4, 3'd5} && stk.size() < 2) ||
                (op == 3'd6 && stk.size() == 16)) begin
                m_err = 1;
                m_cyc += 2;
                break;
            end
            m_cyc += 3;
            m_iss.push_back(prog[i]);
            if (op == 3'd6) begin
                stk.push_back(sx(prog[i][3:0]));
            end else if (op == 3'd7) begin
                m_res = stk.pop_back() & 15;
                m_rv++;
            end else begin
                a = stk.pop_back();
                b = stk.pop_back();
                s = (op == 3'd4) ? a + b : a * b;
                if (s > 7 || s < -8) m_ovf = 1;
                stk.push_back(wrap4(s));
            end
        end
        m_cyc += 1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_res = 0;
    endtask

    task automatic load();
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            prog_we = 1'b1; prog_addr = 5'(i); prog_wdata = prog[i];
        end
        @(posedge clk); #1 prog_we = 1'b0;
    endtask

    // Launch a run; inj>0 pokes prog_we/start in that busy cycle,
    // dstart raises start during the DONE cycle.
    task automatic run(input string nm, input int inj, input bit dstart,
                       output int n);
        int mism;
        model();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 1;
        forever begin
            @(negedge clk);
            if (done || n >= 300) break;
            @(posedge clk); #1;
            n++;
            if (n == inj) begin
                prog_we = 1'b1; prog_addr = 5'd0;
                prog_wdata = 7'h00; start = 1'b1;
            end else begin
                prog_we = 1'b0; start = 1'b0;
            end
        end
        start = dstart;
        @(posedge clk); #1 start = 1'b0; prog_we = 1'b0;
        @(negedge clk);
        if (dstart) check({nm, ".busy_after_done_start"}, int'(busy), 0);
        @(negedge clk);
        check({nm, ".done_cycle"}, n, m_cyc);
        check({nm, ".result"}, int'(result), m_res);
        check({nm, ".ovf"}, int'(ovf_flag), m_ovf);
        check({nm, ".error"}, int'(error), m_err);
        check({nm, ".pc"}, int'(pc), m_pc);
        check({nm, ".rv_pulses"}, rvc, m_rv);
        check({nm, ".done_pulses"}, donec, 1);
        check({nm, ".issued"}, iss_q.size(), m_iss.size());
        mism = 0;
        for (int i = 0; i < iss_q.size() && i < m_iss.size(); i++) begin
            if (iss_q[i] != m_iss[i]) mism++;
        end
        check({nm, ".issue_seq"}, mism, 0);
        check({nm, ".nop_gap"}, b2b, 0);
        check({nm, ".idle_data"}, dbad, 0);
    endtask

    typedef struct {
        logic [6:0] w [5];
        int res, ov, er, p, cy;
    } vec_t;
    vec_t tbl [8];

    task automatic row(input int k, input logic [6:0] w0, w1, w2, w3, w4,
                       input int res, ov, er, p, cy);
        tbl[k].w[0] = w0; tbl[k].w[1] = w1; tbl[k].w[2] = w2;
        tbl[k].w[3] = w3; tbl[k].w[4] = w4;
        tbl[k].res = res; tbl[k].ov = ov; tbl[k].er = er;
        tbl[k].p = p; tbl[k].cy = cy;
    endtask

    task automatic set_row(input int k);
        for (int i = 0; i < 32; i++) prog[i] = 7'h00;
        for (int i = 0; i < 5; i++) prog[i] = tbl[k].w[i];
    endtask

    task automatic cmp_row(input int k, input string nm, input int n);
        check({nm, ".t_result"}, int'(result), tbl[k].res);
        check({nm, ".t_ovf"}, int'(ovf_flag), tbl[k].ov);
        check({nm, ".t_error"}, int'(error), tbl[k].er);
        check({nm, ".t_pc"}, int'(pc), tbl[k].p);
        check({nm, ".t_cycle"}, n, tbl[k].cy);
    endtask

    initial begin
        int n;
        int r;
        // PUSH=6x, ADD=40, MUL=50, POP=70, HALT=00
        row(0, 7'h67, 7'h67, 7'h40, 7'h70, 7'h00, 14, 1, 0, 4, 15);
        row(1, 7'h63, 7'h62, 7'h50, 7'h70, 7'h00, 6, 0, 0, 4, 15);
        row(2, 7'h70, 7'h00, 7'h00, 7'h00, 7'h00, 0, 0, 1, 0, 3);
        row(3, 7'h00, 7'h67, 7'h00, 7'h00, 7'h00, 0, 0, 0, 0, 3);
        row(4, 7'h68, 7'h6F, 7'h40, 7'h70, 7'h00, 7, 1, 0, 4, 15);
        row(5, 7'h65, 7'h20, 7'h70, 7'h00, 7'h00, 0, 0, 1, 1, 6);
        row(6, 7'h62, 7'h50, 7'h70, 7'h00, 7'h00, 0, 0, 1, 1, 6);
        row(7, 7'h6E, 7'h63, 7'h50, 7'h70, 7'h00, 10, 0, 0, 4, 15);

        do_reset();
        @(negedge clk);
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.error", int'(error), 0);
        check("rst.pc", int'(pc), 0);
        check("rst.result", int'(result), 0);
        check("rst.rv", int'(result_valid), 0);
        check("rst.ovf", int'(ovf_flag), 0);
        check("rst.opcode", int'(alu_opcode), 0);
        check("rst.data", int'(alu_data), 0);

        for (int k = 0; k < 8; k++) begin
            set_row(k);
            do_reset();
            load();
            run($sformatf("row%0d", k), 0, 1'b0, n);
            cmp_row(k, $sformatf("row%0d", k), n);
        end

        // 17 pushes: the 17th meets a full stack
        for (int i = 0; i < 32; i++) prog[i] = (i < 17) ? 7'h61 : 7'h00;
        do_reset();
        load();
        run("push17", 0, 1'b0, n);
        check("push17.pc16", int'(pc), 16);
        check("push17.err", int'(error), 1);

        // runs off the last address without wrapping
        for (int i = 0; i < 32; i++) prog[i] = i[0] ? 7'h70 : 7'h61;
        do_reset();
        load();
        run("lastaddr", 0, 1'b0, n);
        check("lastaddr.pc31", int'(pc), 31);

        // reset during SETTLE of the third instruction, then rerun
        set_row(0);
        do_reset();
        load();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_res = 0;
        @(negedge clk);
        check("midrst.busy", int'(busy), 0);
        check("midrst.pc", int'(pc), 0);
        check("midrst.opcode", int'(alu_opcode), 0);
        run("midrst_rerun", 0, 1'b0, n);
        cmp_row(0, "midrst_rerun", n);

        // prog_we/start while busy, start during DONE, then restart
        run("busy_poke", 5, 1'b1, n);
        cmp_row(0, "busy_poke", n);
        run("after_poke", 0, 1'b0, n);
        cmp_row(0, "after_poke", n);

        // randomized programs against the model
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 32; i++) begin
                r = int'($urandom_range(0, 99));
                prog[i][3:0] = 4'($urandom);
                if (r < 45)      prog[i][6:4] = 3'b110;
                else if (r < 60) prog[i][6:4] = 3'b100;
                else if (r < 72) prog[i][6:4] = 3'b101;
                else if (r < 93) prog[i][6:4] = 3'b111;
                else if (r < 96) prog[i][6:4] = 3'($urandom_range(1, 3));
                else             prog[i][6:4] = 3'b000;
            end
            do_reset();
            load();
            run($sformatf("rand%0d", t), 0, 1'b0, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
